regfile_writer: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_writer.sv | 161 ++++++++++++++++
 tb/tb_regfile_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the register-file write front end.
package cpu_pkg;

  // Load transfer size; encoding 3 is treated as a word by consumers.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ld_size_t;

  // Number of consecutive lost contended cycles before the ALU is forced through.
  localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when decode reserves a
// destination, cleared on the same edge the register file captures the write.
// Register 0 is never reserved and always reports not busy.
module regfile_scoreboard #(
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid_i,
  input  logic [M-1:0] issue_rd_i,
  output logic         issue_ready_o,
  input  logic         commit_i,
  input  logic [M-1:0] commit_rd_i,
  input  logic [M-1:0] q_r1_i,
  input  logic [M-1:0] q_r2_i,
  output logic         busy1_o,
  output logic         busy2_o
);

  localparam int R = 1 << M;

  logic [R-1:0] pending_q;
  logic [R-1:0] pending_d;
  logic         issue_fire;

  // A second reservation of a register already in flight must wait.
  assign issue_ready_o = !pending_q[issue_rd_i] || (issue_rd_i == '0);
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  assign busy1_o = (q_r1_i != '0) && pending_q[q_r1_i];
  assign busy2_o = (q_r2_i != '0) && pending_q[q_r2_i];

  // Next pending state: apply the commit clear first, then the new reservation.
  always_comb begin
    pending_d = pending_q;
    if (commit_i) begin
      pending_d[commit_rd_i] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_fire) begin
      pending_d[issue_rd_i] = 1'b1;
    end else begin
      pending_d[0] = pending_d[0];
    end
  end

  // Pending array register; reset drops every reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile_writer.sv
// Write-port front end for the register file: arbitrates ALU and load results
// onto one registered masked write port, aligning partial loads into their lane.
// Optional scoreboard enabled by defining REGFILE_WRITER_SCOREBOARD_EN.
module regfile_writer
  import cpu_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int M  = 2,
  localparam int OW = $clog2(N / 8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [M-1:0]  alu_rd,
  input  logic [N-1:0]  alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [M-1:0]  ld_rd,
  input  logic [1:0]    ld_size,
  input  logic [OW-1:0] ld_off,
  input  logic [N-1:0]  ld_data,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [M-1:0]  issue_rd,
  input  logic [M-1:0]  q_r1,
  input  logic [M-1:0]  q_r2,
  output logic          busy1,
  output logic          busy2,
  output logic          wf,
  output logic [M-1:0]  w1,
  output logic [N-1:0]  w,
  output logic [N-1:0]  mask
);

  logic [1:0]    starve_q, starve_d;
  logic          wf_q, wf_d;
  logic [M-1:0]  w1_q, w1_d;
  logic [N-1:0]  w_q, w_d;
  logic [N-1:0]  mask_q, mask_d;

  logic          override;
  logic          ld_acc;
  logic          alu_acc;
  logic [OW-1:0] lane_off;
  logic [N-1:0]  lane_base;
  logic [OW+2:0] lane_shift;
  logic [N-1:0]  ld_mask;
  logic [N-1:0]  ld_w;

  // Loads normally win; a starved ALU with a pending result is forced through.
  assign override  = alu_valid && (starve_q == STARVE_LIMIT);
  assign ld_ready  = !override;
  assign alu_ready = !ld_valid || override;
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_acc   = alu_valid && alu_ready;

  // Lane offset and unshifted mask for the load size (half ignores offset bit 0).
  always_comb begin
    lane_off  = '0;
    lane_base = '0;
    case (ld_size_t'(ld_size))
      SZ_BYTE: begin
        lane_off  = ld_off;
        lane_base = {{(N-8){1'b0}}, 8'hFF};
      end
      SZ_HALF: begin
        lane_off  = {ld_off[OW-1:1], 1'b0};
        lane_base = {{(N-16){1'b0}}, 16'hFFFF};
      end
      default: begin
        lane_off  = '0;
        lane_base = '1;
      end
    endcase
  end

  assign lane_shift = {lane_off, 3'b000};
  assign ld_mask    = lane_base << lane_shift;
  assign ld_w       = (ld_data << lane_shift) & ld_mask;

  // Starvation counter: counts ALU losses to loads, clears when the ALU is taken.
  always_comb begin
    starve_d = starve_q;
    if (alu_acc) begin
      starve_d = 2'd0;
    end else if (alu_valid && ld_acc) begin
      starve_d = starve_q + 2'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Next write-port contents; rd = 0 is consumed without raising the strobe.
  always_comb begin
    wf_d   = 1'b0;
    w1_d   = w1_q;
    w_d    = w_q;
    mask_d = mask_q;
    if (ld_acc) begin
      wf_d   = (ld_rd != '0);
      w1_d   = ld_rd;
      w_d    = ld_w;
      mask_d = ld_mask;
    end else if (alu_acc) begin
      wf_d   = (alu_rd != '0);
      w1_d   = alu_rd;
      w_d    = alu_data;
      mask_d = '1;
    end else begin
      wf_d = 1'b0;
    end
  end

  // Output stage and arbitration state; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 2'd0;
      wf_q     <= 1'b0;
      w1_q     <= '0;
      w_q      <= '0;
      mask_q   <= '0;
    end else begin
      starve_q <= starve_d;
      wf_q     <= wf_d;
      w1_q     <= w1_d;
      w_q      <= w_d;
      mask_q   <= mask_d;
    end
  end

  assign wf   = wf_q;
  assign w1   = w1_q;
  assign w    = w_q;
  assign mask = mask_q;

`ifdef REGFILE_WRITER_SCOREBOARD_EN
  regfile_scoreboard #(.M(M)) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .commit_i      (wf_q),
    .commit_rd_i   (w1_q),
    .q_r1_i        (q_r1),
    .q_r2_i        (q_r2),
    .busy1_o       (busy1),
    .busy2_o       (busy2)
  );
`else
  logic unused_sb_inputs;

  // Scoreboard ports kept for pin compatibility only.
  assign unused_sb_inputs = ^{issue_valid, issue_rd, q_r1, q_r2};
  assign issue_ready      = 1'b1;
  assign busy1            = 1'b0;
  assign busy2            = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: table of single-transfer vectors plus
// hand-written sequences for contention, scoreboard and mid-operation reset.
module tb_regfile_writer;

`ifdef REGFILE_WRITER_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [1:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [1:0]  ld_rd, ld_size, ld_off;
  logic [31:0] ld_data;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_rd, q_r1, q_r2;
  logic        busy1, busy2;
  logic        wf;
  logic [1:0]  w1;
  logic [31:0] w, mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_writer #(.N(32), .M(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_size(ld_size),
    .ld_off(ld_off), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .q_r1(q_r1), .q_r2(q_r2), .busy1(busy1), .busy2(busy2),
    .wf(wf), .w1(w1), .w(w), .mask(mask)
  );

  typedef struct {
    logic        alu_v;
    logic [1:0]  alu_rd;
    logic [31:0] alu_d;
    logic        ld_v;
    logic [1:0]  ld_rd;
    logic [1:0]  ld_sz;
    logic [1:0]  ld_off;
    logic [31:0] ld_d;
    logic        e_wf;
    logic [1:0]  e_w1;
    logic [31:0] e_w;
    logic [31:0] e_mask;
    logic        chk_data;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 2'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 2'd0; ld_size = 2'd0; ld_off = 2'd0; ld_data = 32'd0;
    issue_valid = 1'b0;
  endtask

  // Reserve a destination for one cycle, checking it was accepted as expected.
  task automatic do_issue(input logic [1:0] rd, input string nm);
    issue_valid = 1'b1; issue_rd = rd;
    @(negedge clk);
    check(nm, {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0;
  endtask

  // Single-cycle ALU transfer, accepted at the edge ending this cycle.
  task automatic do_alu(input logic [1:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    tick();
    alu_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]  cnt;
    logic        exp_alu;
    logic [31:0] exp_d;
    int          alu_seen;

    vecs[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 2'd0, 2'd0, 2'd0, 32'h0,       1'b1, 2'd2, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 2'd0, 2'd2, 32'h000000A5, 1'b1, 2'd1, 32'h00A50000, 32'h00FF0000, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 2'd1, 2'd3, 32'h00001234, 1'b1, 2'd1, 32'h12340000, 32'hFFFF0000, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 2'd0, 2'd0, 32'hFFFFFF7E, 1'b1, 2'd2, 32'h0000007E, 32'h000000FF, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 2'd0, 2'd3, 32'h00000011, 1'b1, 2'd3, 32'h11000000, 32'hFF000000, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 2'd1, 2'd0, 32'hAAAA5555, 1'b1, 2'd2, 32'h00005555, 32'h0000FFFF, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 2'd1, 2'd1, 32'h0000BEEF, 1'b1, 2'd1, 32'h0000BEEF, 32'h0000FFFF, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 2'd2, 2'd3, 32'hCAFEF00D, 1'b1, 2'd3, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 2'd3, 2'd1, 32'h01020304, 1'b1, 2'd1, 32'h01020304, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{1'b1, 2'd0, 32'h00000055, 1'b0, 2'd0, 2'd0, 2'd0, 32'h0,       1'b0, 2'd0, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b1, 2'd1, 32'h00000000, 1'b0, 2'd0, 2'd0, 2'd0, 32'h0,       1'b1, 2'd1, 32'h00000000, 32'hFFFFFFFF, 1'b1};

    // Reset state.
    rst = 1'b1;
    idle_inputs();
    issue_rd = 2'd3; q_r1 = 2'd3; q_r2 = 2'd1;
    repeat (3) tick();
    check("reset_wf", {31'd0, wf}, 32'd0);
    check("reset_w1", {30'd0, w1}, 32'd0);
    check("reset_w", w, 32'd0);
    check("reset_mask", mask, 32'd0);
    check("reset_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_busy2", {31'd0, busy2}, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven single transfers.
    for (int i = 0; i < 11; i++) begin
      alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
      ld_valid = vecs[i].ld_v; ld_rd = vecs[i].ld_rd; ld_size = vecs[i].ld_sz;
      ld_off = vecs[i].ld_off; ld_data = vecs[i].ld_d;
      @(negedge clk);
      check($sformatf("v%0d_ld_ready", i), {31'd0, ld_ready}, 32'd1);
      check($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, !vecs[i].ld_v});
      tick();
      idle_inputs();
      check($sformatf("v%0d_wf", i), {31'd0, wf}, {31'd0, vecs[i].e_wf});
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_w1", i), {30'd0, w1}, {30'd0, vecs[i].e_w1});
        check($sformatf("v%0d_w", i), w, vecs[i].e_w);
        check($sformatf("v%0d_mask", i), mask, vecs[i].e_mask);
      end
      tick();
      check($sformatf("v%0d_wf_idle", i), {31'd0, wf}, 32'd0);
    end

    // Contention: both sources valid continuously, expect 3 loads then 1 ALU.
    cnt = 2'd0;
    alu_seen = 0;
    for (int k = 0; k < 12; k++) begin
      alu_valid = 1'b1; alu_rd = 2'd2; alu_data = 32'hA0000000 + k;
      ld_valid = 1'b1; ld_rd = 2'd1; ld_size = 2'd2; ld_off = 2'd0; ld_data = 32'h00001000 + k;
      exp_alu = (cnt == 2'd3);
      exp_d = exp_alu ? alu_data : ld_data;
      @(negedge clk);
      check($sformatf("cont%0d_alu_ready", k), {31'd0, alu_ready}, {31'd0, exp_alu});
      check($sformatf("cont%0d_ld_ready", k), {31'd0, ld_ready}, {31'd0, !exp_alu});
      tick();
      check($sformatf("cont%0d_wf", k), {31'd0, wf}, 32'd1);
      check($sformatf("cont%0d_w1", k), {30'd0, w1}, exp_alu ? 32'd2 : 32'd1);
      check($sformatf("cont%0d_w", k), w, exp_d);
      if (w[31:28] == 4'hA) alu_seen++;
      cnt = exp_alu ? 2'd0 : cnt + 2'd1;
    end
    idle_inputs();
    check("cont_alu_count", alu_seen, 32'd3);
    tick();
    check("cont_wf_idle", {31'd0, wf}, 32'd0);

    // Scoreboard: reserve r3, query it, second reservation stalls.
    q_r1 = 2'd3; q_r2 = 2'd2;
    do_issue(2'd3, "sb_issue_r3_ready");
    @(negedge clk);
    check("sb_busy1_r3", {31'd0, busy1}, {31'd0, SB});
    check("sb_busy2_r2", {31'd0, busy2}, 32'd0);
    issue_valid = 1'b1; issue_rd = 2'd3;
    @(negedge clk);
    check("sb_second_issue_r3", {31'd0, issue_ready}, {31'd0, !SB});
    tick();
    issue_valid = 1'b0;
    if (!SB) begin
      // Without the scoreboard the second reservation above was also accepted.
      @(negedge clk);
      check("sb_nosb_busy1", {31'd0, busy1}, 32'd0);
    end else begin
      @(negedge clk);
      check("sb_busy1_still", {31'd0, busy1}, 32'd1);
    end
    tick();

    // ALU commit to r3 at t: busy still high in t+1, low at t+2.
    do_alu(2'd3, 32'h33333333);
    @(negedge clk);
    check("sb_commit_wf", {31'd0, wf}, 32'd1);
    check("sb_busy_t1", {31'd0, busy1}, {31'd0, SB});
    tick();
    check("sb_busy_t2", {31'd0, busy1}, 32'd0);
    check("sb_issue_ready_t2", {31'd0, issue_ready}, 32'd1);

    // Same-cycle set of r2 and clear of r1 both take effect.
    do_issue(2'd1, "sb_issue_r1");
    do_alu(2'd1, 32'h11111111);
    do_issue(2'd2, "sb_issue_r2_during_commit");
    q_r1 = 2'd1; q_r2 = 2'd2;
    @(negedge clk);
    check("sb_setclr_busy_r1", {31'd0, busy1}, 32'd0);
    check("sb_setclr_busy_r2", {31'd0, busy2}, {31'd0, SB});
    tick();

    // Reset during the output-stage cycle drops the write and all reservations.
    do_issue(2'd3, "sb_issue_r3_prerst");
    q_r1 = 2'd3; q_r2 = 2'd2;
    do_alu(2'd1, 32'h0BADF00D);
    rst = 1'b1;
    check("rst_mid_wf_before", {31'd0, wf}, 32'd1);
    tick();
    rst = 1'b0;
    issue_rd = 2'd2;
    check("rst_mid_wf", {31'd0, wf}, 32'd0);
    check("rst_mid_busy1", {31'd0, busy1}, 32'd0);
    check("rst_mid_busy2", {31'd0, busy2}, 32'd0);
    check("rst_mid_issue_ready", {31'd0, issue_ready}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
